// File: rtl/boot_ctrl.sv
// rtl/boot_ctrl.sv - boot sequencer: reset wait, boot-address config write, image load wait, fetch enable, run monitor
module boot_ctrl #(
  parameter int unsigned RST_WAIT      = 12,
  parameter logic [31:0] BOOT_REG_ADDR = 32'h1A10_7008,
  parameter logic [31:0] BOOT_ADDR     = 32'h0000_0000,
  parameter int unsigned FETCH_DELAY   = 5,
  parameter int unsigned TIMEOUT       = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode_i,
  input  logic        load_done_i,
  output logic        wr_valid_o,
  input  logic        wr_ready_i,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  input  logic        wr_err_i,
  output logic        fetch_enable_o,
  input  logic        eoc_i,
  output logic        done_o,
  output logic [1:0]  status_o,
  output logic [31:0] cycle_cnt_o
);

  localparam logic [31:0] RST_WAIT_C    = 32'(RST_WAIT);
  localparam logic [31:0] FETCH_DELAY_C = 32'(FETCH_DELAY);
  localparam logic [31:0] TIMEOUT_C     = 32'(TIMEOUT);

  localparam logic [1:0] ST_BUSY    = 2'b00;
  localparam logic [1:0] ST_PASS    = 2'b01;
  localparam logic [1:0] ST_CFG_ERR = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT, S_CFG_WR, S_LOAD_WAIT, S_FETCH_DLY, S_RUN, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] dly_cnt_q, dly_cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic        load_seen_q, load_seen_d;
  logic        wr_valid_d, fetch_en_d, done_d;
  logic [31:0] wr_addr_d, wr_data_d, cycle_cnt_d;
  logic [1:0]  status_d;
  logic        timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cycle_cnt_o == TIMEOUT_C - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_WAIT;
      dly_cnt_q      <= '0;
      mode_q         <= 2'b00;
      load_seen_q    <= 1'b0;
      wr_valid_o     <= 1'b0;
      wr_addr_o      <= '0;
      wr_data_o      <= '0;
      fetch_enable_o <= 1'b0;
      done_o         <= 1'b0;
      status_o       <= ST_BUSY;
      cycle_cnt_o    <= '0;
    end else begin
      state_q        <= state_d;
      dly_cnt_q      <= dly_cnt_d;
      mode_q         <= mode_d;
      load_seen_q    <= load_seen_d;
      wr_valid_o     <= wr_valid_d;
      wr_addr_o      <= wr_addr_d;
      wr_data_o      <= wr_data_d;
      fetch_enable_o <= fetch_en_d;
      done_o         <= done_d;
      status_o       <= status_d;
      cycle_cnt_o    <= cycle_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    mode_d      = mode_q;
    // A loader pulse may arrive while the config write is still pending.
    load_seen_d = load_seen_q | (load_done_i && (state_q != S_WAIT));
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_o;
    wr_data_d   = wr_data_o;
    fetch_en_d  = fetch_enable_o;
    done_d      = done_o;
    status_d    = status_o;
    cycle_cnt_d = cycle_cnt_o;

    case (state_q)
      S_WAIT: begin
        if (dly_cnt_q >= RST_WAIT_C) begin
          mode_d    = mode_i;
          dly_cnt_d = '0;
          if (mode_d == 2'b00) begin
            state_d = S_FETCH_DLY;
          end else begin
            state_d    = S_CFG_WR;
            wr_valid_d = 1'b1;
            wr_addr_d  = BOOT_REG_ADDR;
            wr_data_d  = BOOT_ADDR;
          end
        end else begin
          dly_cnt_d = dly_cnt_q + 32'd1;
        end
      end
      S_CFG_WR: begin
        if (wr_ready_i) begin
          if (wr_err_i) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            status_d = ST_CFG_ERR;
          end else begin
            state_d = S_LOAD_WAIT;
          end
        end else begin
          wr_valid_d = 1'b1;
        end
      end
      S_LOAD_WAIT: begin
        if (load_seen_q || load_done_i) begin
          state_d   = S_FETCH_DLY;
          dly_cnt_d = '0;
        end
      end
      S_FETCH_DLY: begin
        if (dly_cnt_q + 32'd1 >= FETCH_DELAY_C) begin
          state_d    = S_RUN;
          fetch_en_d = 1'b1;
        end else begin
          dly_cnt_d = dly_cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        cycle_cnt_d = (cycle_cnt_o == 32'hFFFF_FFFF) ? cycle_cnt_o : cycle_cnt_o + 32'd1;
        // End of computation takes priority over a coincident timeout.
        if (eoc_i) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          status_d = ST_PASS;
        end else if (timeout_hit) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          status_d   = ST_TIMEOUT;
          fetch_en_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// tb/tb_boot_ctrl.sv - scoreboard bench for boot_ctrl (default instance plus TIMEOUT=50 instance)
module tb_boot_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rst_n_b;
  logic [1:0]  mode;
  logic        load_done, wr_ready, wr_err, eoc_a, eoc_b;

  logic        wr_valid_a, fetch_a, done_a;
  logic [31:0] wr_addr_a, wr_data_a, cnt_a;
  logic [1:0]  status_a;
  logic        wr_valid_b, fetch_b, done_b;
  logic [31:0] wr_addr_b, wr_data_b, cnt_b;
  logic [1:0]  status_b;

  boot_ctrl dut_a (
    .clk(clk), .rst_n(rst_n_a), .mode_i(mode), .load_done_i(load_done),
    .wr_valid_o(wr_valid_a), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr_a),
    .wr_data_o(wr_data_a), .wr_err_i(wr_err), .fetch_enable_o(fetch_a),
    .eoc_i(eoc_a), .done_o(done_a), .status_o(status_a), .cycle_cnt_o(cnt_a)
  );

  boot_ctrl #(.TIMEOUT(50)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .mode_i(mode), .load_done_i(load_done),
    .wr_valid_o(wr_valid_b), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr_b),
    .wr_data_o(wr_data_b), .wr_err_i(wr_err), .fetch_enable_o(fetch_b),
    .eoc_i(eoc_b), .done_o(done_b), .status_o(status_b), .cycle_cnt_o(cnt_b)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] hold;
  } wr_exp_t;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] cnt;
    logic        fetch;
  } done_exp_t;

  wr_exp_t   wr_q[$];
  int        fetch_q[$];
  done_exp_t done_q_a[$];
  done_exp_t done_q_b[$];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int cyc_a, cyc_b;
  always @(posedge clk or negedge rst_n_a)
    if (!rst_n_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
  always @(posedge clk or negedge rst_n_b)
    if (!rst_n_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;

  // Monitor for the default instance: write handshakes, fetch rise, done record.
  int        hold_a;
  logic      fetch_prev_a, done_prev_a;
  done_exp_t last_a;
  always @(negedge clk) begin
    if (!rst_n_a) begin
      hold_a       = 0;
      fetch_prev_a = 1'b0;
      done_prev_a  = 1'b0;
    end else begin
      if (wr_valid_a) begin
        if (wr_q.size() == 0) begin
          check("wr_valid_without_request", wr_valid_a, 1'b0);
        end else begin
          check("wr_addr", wr_addr_a, wr_q[0].addr);
          check("wr_data", wr_data_a, wr_q[0].data);
          hold_a++;
          if (wr_ready) begin
            check("wr_hold_cycles", hold_a, wr_q[0].hold);
            void'(wr_q.pop_front());
            hold_a = 0;
          end
        end
      end
      if (fetch_a && !fetch_prev_a) begin
        if (fetch_q.size() == 0) check("unexpected_fetch_rise", fetch_a, 1'b0);
        else check("fetch_rise_cycle", cyc_a, fetch_q.pop_front());
      end
      fetch_prev_a = fetch_a;
      if (done_a && !done_prev_a) begin
        if (done_q_a.size() == 0) check("unexpected_done", done_a, 1'b0);
        else last_a = done_q_a.pop_front();
      end
      done_prev_a = done_a;
      if (done_a) begin
        check("done_status", status_a, last_a.status);
        check("done_cycle_cnt", cnt_a, last_a.cnt);
        check("done_fetch", fetch_a, last_a.fetch);
      end
    end
  end

  logic      done_prev_b;
  done_exp_t last_b;
  always @(negedge clk) begin
    if (!rst_n_b) begin
      done_prev_b = 1'b0;
    end else begin
      if (done_b && !done_prev_b) begin
        if (done_q_b.size() == 0) check("unexpected_done_b", done_b, 1'b0);
        else last_b = done_q_b.pop_front();
      end
      done_prev_b = done_b;
      if (done_b) begin
        check("b_done_status", status_b, last_b.status);
        check("b_done_cycle_cnt", cnt_b, last_b.cnt);
        check("b_done_fetch", fetch_b, last_b.fetch);
      end
    end
  end

  task automatic check_reset_a();
    check("rst_wr_valid", wr_valid_a, 1'b0);
    check("rst_wr_addr", wr_addr_a, 32'h0);
    check("rst_wr_data", wr_data_a, 32'h0);
    check("rst_fetch", fetch_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_status", status_a, 2'b00);
    check("rst_cycle_cnt", cnt_a, 32'h0);
  endtask

  task automatic wait_a(input int n);
    while (cyc_a < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_b(input int n);
    while (cyc_b < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Assert reset asynchronously, verify outputs drop before any clock edge, then hold.
  task automatic assert_reset_a();
    rst_n_a = 1'b0;
    #1;
    check_reset_a();
    wr_q.delete();
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic release_a(input logic [1:0] m, input logic rdy, input logic err);
    mode     = m;
    wr_ready = rdy;
    wr_err   = err;
    rst_n_a  = 1'b1;
  endtask

  localparam logic [31:0] REG_A = 32'h1A10_7008;

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    mode = 2'b00; load_done = 1'b0; wr_ready = 1'b0; wr_err = 1'b0;
    eoc_a = 1'b0; eoc_b = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_a();
    check("b_rst_done", done_b, 1'b0);
    check("b_rst_cycle_cnt", cnt_b, 32'h0);

    // mode 01: immediate accept, load 20 cycles after request, eoc at RUN cycle 100
    wr_q.push_back('{addr: REG_A, data: 32'h0, hold: 32'd1});
    fetch_q.push_back(39);
    done_q_a.push_back('{status: 2'b01, cnt: 32'd100, fetch: 1'b1});
    release_a(2'b01, 1'b1, 1'b0);
    wait_a(33); load_done = 1'b1;
    wait_a(34); load_done = 1'b0; mode = 2'b00;
    wait_a(138); eoc_a = 1'b1;
    wait_a(141); eoc_a = 1'b0;
    wait_a(145);
    assert_reset_a();

    // mode 00: no write, fetch at RST_WAIT+FETCH_DELAY+1
    fetch_q.push_back(18);
    done_q_a.push_back('{status: 2'b01, cnt: 32'd5, fetch: 1'b1});
    release_a(2'b00, 1'b1, 1'b0);
    wait_a(22); eoc_a = 1'b1;
    wait_a(23); eoc_a = 1'b0;
    wait_a(28);
    assert_reset_a();

    // mode 10: ready delayed 7 cycles, load pulse during CFG_WR latched
    wr_q.push_back('{addr: REG_A, data: 32'h0, hold: 32'd8});
    fetch_q.push_back(27);
    done_q_a.push_back('{status: 2'b01, cnt: 32'd10, fetch: 1'b1});
    release_a(2'b10, 1'b0, 1'b0);
    wait_a(15); load_done = 1'b1;
    wait_a(16); load_done = 1'b0;
    wait_a(20); wr_ready = 1'b1;
    wait_a(21); wr_ready = 1'b0;
    wait_a(36); eoc_a = 1'b1;
    wait_a(37); eoc_a = 1'b0;
    wait_a(40);
    assert_reset_a();

    // mode 11 with write error: config error, fetch never enabled
    wr_q.push_back('{addr: REG_A, data: 32'h0, hold: 32'd1});
    done_q_a.push_back('{status: 2'b10, cnt: 32'd0, fetch: 1'b0});
    release_a(2'b11, 1'b1, 1'b1);
    wait_a(20); load_done = 1'b1; eoc_a = 1'b1;
    wait_a(21); load_done = 1'b0; eoc_a = 1'b0;
    wait_a(30);
    wr_err = 1'b0;
    assert_reset_a();

    // reset during a pending write, then full sequence
    wr_q.push_back('{addr: REG_A, data: 32'h0, hold: 32'd10});
    release_a(2'b01, 1'b0, 1'b0);
    wait_a(16);
    assert_reset_a();
    wr_q.push_back('{addr: REG_A, data: 32'h0, hold: 32'd1});
    fetch_q.push_back(26);
    done_q_a.push_back('{status: 2'b01, cnt: 32'd3, fetch: 1'b1});
    release_a(2'b01, 1'b1, 1'b0);
    wait_a(20); load_done = 1'b1;
    wait_a(21); load_done = 1'b0;
    wait_a(28); eoc_a = 1'b1;
    wait_a(29); eoc_a = 1'b0;
    wait_a(32);
    assert_reset_a();

    // reset during RUN, then full sequence
    fetch_q.push_back(18);
    release_a(2'b00, 1'b1, 1'b0);
    wait_a(25);
    assert_reset_a();
    fetch_q.push_back(18);
    done_q_a.push_back('{status: 2'b01, cnt: 32'd5, fetch: 1'b1});
    release_a(2'b00, 1'b1, 1'b0);
    wait_a(22); eoc_a = 1'b1;
    wait_a(23); eoc_a = 1'b0;
    wait_a(28);
    assert_reset_a();

    // TIMEOUT=50 instance: pure timeout, then eoc coincident with timeout
    mode = 2'b00;
    done_q_b.push_back('{status: 2'b11, cnt: 32'd50, fetch: 1'b0});
    rst_n_b = 1'b1;
    wait_b(73);
    rst_n_b = 1'b0;
    #1;
    check("b_async_rst_done", done_b, 1'b0);
    check("b_async_rst_cnt", cnt_b, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    done_q_b.push_back('{status: 2'b01, cnt: 32'd50, fetch: 1'b1});
    rst_n_b = 1'b1;
    wait_b(67); eoc_b = 1'b1;
    wait_b(70); eoc_b = 1'b0;
    wait_b(75);

    check("wr_queue_drained", wr_q.size(), 0);
    check("fetch_queue_drained", fetch_q.size(), 0);
    check("done_queue_a_drained", done_q_a.size(), 0);
    check("done_queue_b_drained", done_q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d failures", checks, fails);
    $fatal(1);
  end

endmodule
